pipe_stage_reg: RTL

//  Generic parametrised inter-stage pipeline register for the five-stage MIPS pipeline.

---
 rtl/cpu_types_pkg.sv | 75 +++++++
 rtl/pipe_stage_reg.sv | 90 +++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: inter-stage register FSM encoding and the per-stage bundle layouts.
// Each *_BUBBLE constant is the NOP bundle that a flushed or empty stage register presents.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'b00,
        PS_FULL  = 2'b01,
        PS_SKID  = 2'b10
    } pipe_state_t;

    localparam int unsigned STAGE_BUS_W = 160;

    // Any encoding outside the three legal states counts as holding nothing.
    function automatic logic [1:0] state_occupancy(input pipe_state_t s);
        case (s)
            PS_FULL: return 2'd1;
            PS_SKID: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_dst;
        logic        branch;
        logic        jump;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
    } idex_t;

    typedef struct packed {
        logic [31:0] branch_tgt;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  dst_reg;
        logic        zero;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
    } exmem_t;

    typedef struct packed {
        logic [31:0] load_val;
        logic [31:0] alu_res;
        logic [4:0]  dst_reg;
        logic        mem_to_reg;
        logic        reg_write;
    } memwb_t;

    // All control bits low means no write-back and no memory access: a true NOP.
    localparam ifid_t  IFID_BUBBLE  = '0;
    localparam idex_t  IDEX_BUBBLE  = '0;
    localparam exmem_t EXMEM_BUBBLE = '0;
    localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional 2-entry skid
// buffer and a bubble value presented whenever the register is empty or flushed.
module pipe_stage_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned      WIDTH   = STAGE_BUS_W,
    parameter logic [WIDTH-1:0] BUBBLE  = '0,
    parameter bit               SKID_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    pipe_state_t      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_out_valid;
    logic w_in_ready;
    logic w_in_xfer;
    logic w_out_xfer;

    assign w_out_valid = (r_state == PS_FULL) || (r_state == PS_SKID);

    // With the skid entry, ready depends only on flops; without it ready must look downstream.
    generate
        if (SKID_EN) begin : g_skid
            assign w_in_ready = (r_state != PS_SKID);
        end else begin : g_noskid
            assign w_in_ready = !w_out_valid || out_ready;
        end
    endgenerate

    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_out_xfer = w_out_valid && out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= PS_EMPTY;
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
        end else if (flush) begin
            r_state <= PS_EMPTY;
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
        end else begin
            case (r_state)
                PS_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main <= in_data;
                    end else if (w_in_xfer && SKID_EN) begin
                        r_state <= PS_SKID;
                        r_skid  <= in_data;
                    end else if (w_out_xfer) begin
                        r_state <= PS_EMPTY;
                        r_main  <= BUBBLE;
                    end
                end
                PS_SKID: begin
                    // Older entry leaves; the younger one moves up so main stays oldest.
                    if (out_ready) begin
                        r_state <= PS_FULL;
                        r_main  <= r_skid;
                        r_skid  <= BUBBLE;
                    end
                end
                default: begin
                    if (w_in_xfer) begin
                        r_state <= PS_FULL;
                        r_main  <= in_data;
                    end
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign occupancy = state_occupancy(r_state);

endmodule
